// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_CLAIMED = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam logic [31:0] DEF_MASK_ADDR  = 32'hffff0070;
  localparam logic [31:0] DEF_CAUSE_ADDR = 32'hffff0074;
  localparam logic [31:0] DEF_ACK_ADDR   = 32'hffff0078;

  // CAUSE register field positions
  localparam int VALID    = 31;
  localparam int ERR      = 30;
  localparam int PEND_LSB = 8;
  localparam int ID_MSB   = 7;

endpackage

// File: rtl/irq_controller_if.sv
// Shared CPU memory bus as seen by the interrupt controller.
interface irq_controller_if;
  logic [31:0] address;
  logic [31:0] data;
  logic        MemRead;
  logic        MemWrite;
  logic        CtrlAddress;

  modport master (output address, data, MemRead, MemWrite, input CtrlAddress);
  modport slave  (input address, data, MemRead, MemWrite, output CtrlAddress);
endinterface

// File: rtl/irq_prio_enc.sv
// Priority encoder: lowest set index wins; any flags a non-empty vector.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [2:0]   id,
  output logic         any
);
  // Scan from the top so the lowest set bit is written last
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) id = 3'(i);
  end

  assign any = |vec;
endmodule

// File: rtl/register.sv
// Enable-gated register with synchronous active-high reset.
module register #(
  parameter int           W   = 32,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Load d when enabled; reset wins
  always_ff @(posedge clock) begin
    if (reset)   q <= RST;
    else if (en) q <= d;
  end
endmodule

// File: rtl/tristate.sv
// Tristate bus driver: drives a when en, high-Z otherwise.
module tristate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output wire  [W-1:0] y
);
  assign y = en ? a : {W{1'bz}};
endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: mask, prioritise, claim/ack handshake.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] MASK_ADDR  = DEF_MASK_ADDR,
  parameter logic [31:0] CAUSE_ADDR = DEF_CAUSE_ADDR,
  parameter logic [31:0] ACK_ADDR   = DEF_ACK_ADDR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  irq_controller_if.slave    bus,
  output logic               InterruptReq,
  output logic [NUM_SRC-1:0] ack_out,
  output wire  [31:0]        rdata
);

  // Only the global enable and the per-source enables are storable
  localparam logic [31:0] MASK_BITS = 32'h8000_0000 | 32'((1 << NUM_SRC) - 1);

  state_t             state;
  logic [31:0]        mask_q;
  logic [0:0]         err_q;
  logic [2:0]         claim_q;
  logic [NUM_SRC-1:0] mpend;
  logic [2:0]         win_id;
  logic               any_pend;
  logic [31:0]        cause;

  logic hit_mask, hit_cause, hit_ack;
  logic mask_wr, cause_rd, ack_wr, ack_ok, bad_ack, claim_take, rd_hit;

  assign hit_mask        = (bus.address == MASK_ADDR);
  assign hit_cause       = (bus.address == CAUSE_ADDR);
  assign hit_ack         = (bus.address == ACK_ADDR);
  assign bus.CtrlAddress = hit_mask | hit_cause | hit_ack;

  assign mask_wr  = bus.MemWrite & hit_mask;
  assign cause_rd = bus.MemRead  & hit_cause;
  assign ack_wr   = bus.MemWrite & hit_ack;

  assign mpend = mask_q[31] ? (irq_in & mask_q[NUM_SRC-1:0]) : '0;

  irq_prio_enc #(.N(NUM_SRC)) u_enc (.vec(mpend), .id(win_id), .any(any_pend));

  assign claim_take = (state == ST_ASSERT) && any_pend && cause_rd;
  assign ack_ok     = ack_wr && (state == ST_CLAIMED) && (bus.data[7:0] == {5'b0, claim_q});
  assign bad_ack    = ack_wr && !ack_ok;

  register #(.W(32)) u_mask (
    .clock(clock), .reset(reset), .en(mask_wr), .d(bus.data & MASK_BITS), .q(mask_q)
  );

  // Error is sticky on a bad ack; any mask write clears it
  register #(.W(1)) u_err (
    .clock(clock), .reset(reset), .en(mask_wr | bad_ack), .d(~mask_wr), .q(err_q)
  );

  register #(.W(3)) u_claim (
    .clock(clock), .reset(reset), .en(claim_take), .d(win_id), .q(claim_q)
  );

  // CAUSE view: id is live in ASSERT, latched in CLAIMED, zero otherwise
  always_comb begin
    cause           = '0;
    cause[VALID]    = (state == ST_ASSERT) || (state == ST_CLAIMED);
    cause[ERR]      = err_q[0];
    cause[PEND_LSB +: NUM_SRC] = mpend;
    case (state)
      ST_ASSERT:  cause[ID_MSB:0] = 8'(win_id);
      ST_CLAIMED: cause[ID_MSB:0] = 8'(claim_q);
      default:    ;
    endcase
  end

  // Reads see pre-edge state, so a same-cycle write is not visible yet
  assign rd_hit = bus.MemRead & (hit_mask | hit_cause);

  tristate #(.W(32)) u_rd (.en(rd_hit), .a(hit_mask ? mask_q : cause), .y(rdata));

  // Handshake sequencer; InterruptReq and ack_out are registered with the state
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      InterruptReq <= 1'b0;
      ack_out      <= '0;
    end else begin
      ack_out <= '0;
      case (state)
        ST_IDLE:
          if (any_pend) begin
            state        <= ST_ASSERT;
            InterruptReq <= 1'b1;
          end
        ST_ASSERT:
          if (!any_pend) begin
            state        <= ST_IDLE;
            InterruptReq <= 1'b0;
          end else if (cause_rd) begin
            state <= ST_CLAIMED;
          end
        ST_CLAIMED:
          if (ack_ok) begin
            state        <= ST_DRAIN;
            InterruptReq <= 1'b0;
            ack_out      <= NUM_SRC'(1) << claim_q;
          end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a cycle-level reference model.
module tb_irq_controller;

  localparam logic [31:0] A_MASK  = 32'hffff0070;
  localparam logic [31:0] A_CAUSE = 32'hffff0074;
  localparam logic [31:0] A_ACK   = 32'hffff0078;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_in = 4'b0;
  logic        InterruptReq;
  logic [3:0]  ack_out;
  wire  [31:0] rdata;

  irq_controller_if bus ();

  irq_controller #(.NUM_SRC(4)) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .bus(bus),
    .InterruptReq(InterruptReq), .ack_out(ack_out), .rdata(rdata)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model: what the CPU should observe, tracked by handshake phase
  typedef enum {P_IDLE, P_REQ, P_OWN, P_COOL} phase_e;
  phase_e      ph     = P_IDLE;
  logic [31:0] m_mask = '0;
  bit          m_err  = 1'b0;
  int          m_id   = 0;
  logic [3:0]  m_ack  = '0;

  always @(negedge clock) begin : model
    logic [3:0]  pend;
    logic [31:0] cv;
    int          win;
    bit          rdh, wm, rc, wa, good;
    phase_e      nph;

    pend = m_mask[31] ? (irq_in & m_mask[3:0]) : 4'b0;
    win = 0;
    for (int i = 3; i >= 0; i--) if (pend[i]) win = i;

    cv = '0;
    cv[31]   = (ph == P_REQ) || (ph == P_OWN);
    cv[30]   = m_err;
    cv[11:8] = pend;
    cv[7:0]  = (ph == P_REQ) ? 8'(win) : (ph == P_OWN) ? 8'(m_id) : 8'd0;

    rdh = bus.MemRead && (bus.address == A_MASK || bus.address == A_CAUSE);
    wm  = bus.MemWrite && bus.address == A_MASK;
    rc  = bus.MemRead  && bus.address == A_CAUSE;
    wa  = bus.MemWrite && bus.address == A_ACK;

    if (started) begin
      cmp("irq_req", {31'b0, InterruptReq}, {31'b0, (ph == P_REQ || ph == P_OWN)});
      cmp("ack_out", {28'b0, ack_out}, {28'b0, m_ack});
      cmp("ctrl_addr", {31'b0, bus.CtrlAddress},
          {31'b0, (bus.address == A_MASK || bus.address == A_CAUSE || bus.address == A_ACK)});
      if (rdh) cmp("rdata", rdata, (bus.address == A_MASK) ? m_mask : cv);
      else begin
        checks++;
        if (!($isunknown(rdata) || rdata == 32'h0)) begin
          failures++;
          $display("FAIL rdata_hiz: got %h expected undriven", rdata);
        end
      end
    end

    if (reset) begin
      ph = P_IDLE; m_mask = '0; m_err = 1'b0; m_id = 0; m_ack = '0;
    end else begin
      good  = wa && (ph == P_OWN) && (int'(bus.data[7:0]) == m_id);
      m_ack = '0;
      nph   = ph;
      case (ph)
        P_IDLE: if (pend != 0) nph = P_REQ;
        P_REQ:  if (pend == 0) nph = P_IDLE;
                else if (rc) begin nph = P_OWN; m_id = win; end
        P_OWN:  if (good) begin nph = P_COOL; m_ack = 4'(1 << m_id); end
        P_COOL: nph = P_IDLE;
        default: nph = P_IDLE;
      endcase
      if (wa && !good) m_err = 1'b1;
      if (wm) begin m_mask = bus.data & 32'h8000000F; m_err = 1'b0; end
      ph = nph;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic bus_set(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.MemRead = rd; bus.MemWrite = wr; bus.address = a; bus.data = d;
  endtask

  task automatic bus_idle();
    bus_set(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    bus_idle();
    @(posedge clock); started = 1'b1; #1;
    step(1); reset = 1'b0;
    @(negedge clock);
    cmp("rst_irq", {31'b0, InterruptReq}, 32'd0);
    cmp("rst_ack", {28'b0, ack_out}, 32'd0);

    // Enabled source with global mask off stays quiet
    step(1); irq_in = 4'b0001; step(2);
    @(negedge clock); cmp("masked_irq", {31'b0, InterruptReq}, 32'd0);
    step(1);
    bus_set(1'b0, 1'b1, A_MASK, 32'h80000001); step(1); bus_idle();
    @(negedge clock); cmp("mask_edge_irq", {31'b0, InterruptReq}, 32'd0);
    step(1);
    @(negedge clock); cmp("irq_after_mask", {31'b0, InterruptReq}, 32'd1);

    // Priority claim with two sources, repeated read is idempotent
    step(1);
    irq_in = 4'b0110; bus_set(1'b0, 1'b1, A_MASK, 32'h8000000F); step(1); bus_idle();
    step(2);
    bus_set(1'b1, 1'b0, A_CAUSE, 32'h0);
    @(negedge clock); cmp("claim_rd", rdata, 32'h80000601);
    step(1);
    @(negedge clock); cmp("claim_rd2", rdata, 32'h80000601);
    step(1); bus_idle();

    // Matching ack: one-cycle pulse, re-assert two cycles later
    bus_set(1'b0, 1'b1, A_ACK, 32'd1); step(1); bus_idle(); irq_in = 4'b0100;
    @(negedge clock);
    cmp("ack_pulse", {28'b0, ack_out}, 32'h2);
    cmp("ack_irq", {31'b0, InterruptReq}, 32'd0);
    step(1);
    @(negedge clock); cmp("ack_once", {28'b0, ack_out}, 32'h0);
    step(1);
    @(negedge clock); cmp("reassert", {31'b0, InterruptReq}, 32'd1);
    bus_set(1'b1, 1'b0, A_CAUSE, 32'h0);
    @(negedge clock); cmp("claim2", rdata, 32'h80000402);
    step(1); bus_idle();

    // Mismatched ack sets the error; mask write clears it without aborting
    bus_set(1'b0, 1'b1, A_ACK, 32'd3); step(1); bus_idle();
    @(negedge clock);
    cmp("badack_noack", {28'b0, ack_out}, 32'h0);
    cmp("badack_irq", {31'b0, InterruptReq}, 32'd1);
    bus_set(1'b1, 1'b0, A_CAUSE, 32'h0);
    @(negedge clock); cmp("err_set", rdata, 32'hC0000402);
    step(1);
    bus_set(1'b0, 1'b1, A_MASK, 32'h8000000F); step(1);
    bus_set(1'b1, 1'b0, A_CAUSE, 32'h0);
    @(negedge clock); cmp("err_clr", rdata, 32'h80000402);
    step(1);
    bus_set(1'b0, 1'b1, A_ACK, 32'd2); step(1); bus_idle(); irq_in = 4'b0000;
    @(negedge clock); cmp("ack2", {28'b0, ack_out}, 32'h4);
    step(2);

    // Ack while idle is an error too
    bus_set(1'b0, 1'b1, A_ACK, 32'd0); step(1);
    bus_set(1'b1, 1'b0, A_CAUSE, 32'h0);
    @(negedge clock); cmp("idle_ack_err", rdata, 32'h40000000);
    step(1);
    bus_set(1'b0, 1'b1, A_MASK, 32'h8000000F); step(1); bus_idle();

    // Source drops before claim
    irq_in = 4'b0001; step(2);
    bus_set(1'b1, 1'b0, 32'hffff0000, 32'h0);
    @(negedge clock);
    cmp("drop_pre_irq", {31'b0, InterruptReq}, 32'd1);
    cmp("miss_ctrl", {31'b0, bus.CtrlAddress}, 32'd0);
    step(1); bus_idle(); irq_in = 4'b0000; step(1);
    bus_set(1'b1, 1'b0, A_CAUSE, 32'h0);
    @(negedge clock);
    cmp("drop_cause", rdata, 32'h00000000);
    cmp("drop_irq", {31'b0, InterruptReq}, 32'd0);
    step(1);

    // Simultaneous read and write of MASK
    bus_set(1'b1, 1'b1, A_MASK, 32'h80000003);
    @(negedge clock); cmp("rw_pre", rdata, 32'h8000000F);
    step(1); bus_set(1'b1, 1'b0, A_MASK, 32'h0);
    @(negedge clock); cmp("rw_post", rdata, 32'h80000003);
    step(1); bus_idle();

    // Reset in the middle of a claim
    irq_in = 4'b0010; step(2);
    bus_set(1'b1, 1'b0, A_CAUSE, 32'h0);
    @(negedge clock); cmp("pre_rst_claim", rdata, 32'h80000201);
    step(1); bus_idle(); reset = 1'b1;
    step(1); reset = 1'b0;
    @(negedge clock);
    cmp("midrst_irq", {31'b0, InterruptReq}, 32'd0);
    cmp("midrst_ack", {28'b0, ack_out}, 32'h0);
    bus_set(1'b1, 1'b0, A_MASK, 32'h0);
    @(negedge clock); cmp("midrst_mask", rdata, 32'h0);
    step(1); bus_idle(); step(3);
    irq_in = 4'b0000; step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
